// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the Harvard MIPS core: owns the PC, runs the
// imem read handshake and applies delay-slot redirects via a FETCH/EXEC/HALT FSM.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic        imem_waitrequest,
  input  logic [31:0] imem_readdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        active
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pending_target_q;
  logic        pending_valid_q;
  logic        read_q;
  logic        instr_valid_q;
  logic        active_q;

  logic [31:0] pc4_d;
  logic [31:0] pc_d;
  logic        take_redirect_d;

  assign pc4_d = pc_q + 32'd4;
  // A retiring delay slot hands control to the target captured one instruction earlier.
  assign pc_d            = pending_valid_q ? pending_target_q : pc4_d;
  assign take_redirect_d = redirect && !pending_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= FETCH;
      pc_q             <= RESET_VECTOR;
      instr_q          <= '0;
      instr_valid_q    <= 1'b0;
      active_q         <= 1'b1;
      read_q           <= 1'b1;
      pending_valid_q  <= 1'b0;
      pending_target_q <= '0;
    end else if (clk_enable) begin
      case (state_q)
        FETCH: begin
          if (!imem_waitrequest) begin
            instr_q       <= imem_readdata;
            state_q       <= EXEC;
            read_q        <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc_q            <= pc_d;
            instr_valid_q   <= 1'b0;
            pending_valid_q <= take_redirect_d;
            if (take_redirect_d) begin
              pending_target_q <= redirect_target;
            end
            if (pc_d == HALT_ADDR) begin
              state_q  <= HALT;
              active_q <= 1'b0;
              read_q   <= 1'b0;
            end else begin
              state_q <= FETCH;
              read_q  <= 1'b1;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state_q       <= HALT;
          active_q      <= 1'b0;
          read_q        <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Request is masked combinationally so it is already low in the reset cycle.
  assign imem_read    = read_q & ~reset;
  assign imem_address = pc_q;
  assign pc           = pc_q;
  assign pc4          = pc4_d;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign active       = active_q;

endmodule
